// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer between execute and the CSR block.
// Detects trap/mret events on the execute-stage instruction, kills it,
// strobes the CSR hardware-write port on trap entry and redirects fetch.
module trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_ecall,
    input  logic            ex_ebreak,
    input  logic            ex_illegal,
    input  logic            ex_mret,
    input  logic            irq_en,
    input  logic            irq_ext,
    input  logic            irq_timer,
    output logic            ex_kill,
    output logic            trap_busy,
    output logic            ent_trap,
    output logic [XLEN-1:0] csr_wr_mepc_mepc,
    output logic [XLEN-2:0] csr_wr_mcause_exception_code,
    output logic            csr_wr_mcause_interrupt,
    input  logic [XLEN-3:0] csr_rd_mtvec_base,
    input  logic [1:0]      csr_rd_mtvec_mode,
    input  logic [XLEN-1:0] csr_rd_mepc_mepc,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ENTER    = 2'd1,
        S_REDIRECT = 2'd2,
        S_RETURN   = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [XLEN-1:0] mepc_reg;
    logic [XLEN-2:0] code_reg;
    logic            intr_reg;
    logic [XLEN-1:0] target_reg;

    logic            irq_pend;
    logic            take;
    logic            ret;
    logic            cause_int;
    logic [XLEN-2:0] cause_code;
    logic [XLEN-1:0] mtvec_base_addr;
    logic [XLEN-1:0] trap_target;
    logic            is_idle;

    assign is_idle  = (state_reg == S_IDLE);
    assign irq_pend = irq_en & (irq_ext | irq_timer);
    assign take     = ex_valid & (irq_pend | ex_illegal | ex_ebreak | ex_ecall);
    assign ret      = ex_valid & ex_mret & ~take;

    // Cause selection: external irq > timer irq > illegal > ebreak > ecall
    always_comb begin
        cause_int  = 1'b0;
        cause_code = '0;
        if (irq_en && irq_ext) begin
            cause_int  = 1'b1;
            cause_code = (XLEN-1)'(11);
        end else if (irq_en && irq_timer) begin
            cause_int  = 1'b1;
            cause_code = (XLEN-1)'(7);
        end else if (ex_illegal) begin
            cause_code = (XLEN-1)'(2);
        end else if (ex_ebreak) begin
            cause_code = (XLEN-1)'(3);
        end else if (ex_ecall) begin
            cause_code = (XLEN-1)'(11);
        end
    end

    // Vectored mode only applies to interrupts; the sum wraps at XLEN bits
    assign mtvec_base_addr = {csr_rd_mtvec_base, 2'b00};
    always_comb begin
        trap_target = mtvec_base_addr;
        if (csr_rd_mtvec_mode == 2'd1 && intr_reg) begin
            trap_target = mtvec_base_addr + {code_reg[XLEN-4:0], 2'b00};
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (take) begin
                    state_next = S_ENTER;
                end else if (ret) begin
                    state_next = S_RETURN;
                end
            end
            S_ENTER: begin
                state_next = S_REDIRECT;
            end
            S_REDIRECT, S_RETURN: begin
                if (redirect_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Capture trap PC/cause on take and the redirect target on ret/ENTER
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mepc_reg   <= '0;
            code_reg   <= '0;
            intr_reg   <= 1'b0;
            target_reg <= '0;
        end else begin
            if (is_idle && take) begin
                mepc_reg <= ex_pc;
                code_reg <= cause_code;
                intr_reg <= cause_int;
            end
            if (is_idle && ret) begin
                target_reg <= {csr_rd_mepc_mepc[XLEN-1:2], 2'b00};
            end else if (state_reg == S_ENTER) begin
                target_reg <= trap_target;
            end
        end
    end

    // Outputs decoded from state; ex_kill also forced low while rst is high
    always_comb begin
        ex_kill        = ~rst & is_idle & (take | ret);
        trap_busy      = ~is_idle;
        ent_trap       = (state_reg == S_ENTER);
        redirect_valid = (state_reg == S_REDIRECT) || (state_reg == S_RETURN);
    end

    assign csr_wr_mepc_mepc             = mepc_reg;
    assign csr_wr_mcause_exception_code = code_reg;
    assign csr_wr_mcause_interrupt      = intr_reg;
    assign redirect_pc                  = target_reg;

endmodule
